// File: rtl/move_engine.sv
// Othello move sequencer: checks the target cell, scans all eight rays,
// writes flipped discs in direction order and places the new disc last.
module move_engine (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  logic       player,
    output logic [5:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [1:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic [4:0] flips
);

    typedef enum logic [3:0] {
        IDLE, RD_ORG, CHK_ORG, DIR_INIT, SCAN_RD,
        SCAN_EVAL, FLIP, NEXT_DIR, PLACE, DONE
    } state_t;

    state_t     state, state_next;
    logic [2:0] org_r, org_c, cur_r, cur_c;
    logic [2:0] dir, cnt;
    logic       ply;
    logic [4:0] total;
    logic       valid_r;
    logic [4:0] flips_r;

    logic [1:0] own, opp;
    logic [3:0] dr, dc;
    logic [3:0] org_nr, org_nc, cur_nr, cur_nc;
    logic       org_out, cur_out, is_opp, is_own;

    assign own = ply ? 2'b10 : 2'b01;
    assign opp = ply ? 2'b01 : 2'b10;

    // Steps are 4-bit two's complement; -1 and 8 both set bit 3, so bit 3 flags off-board.
    always_comb begin
        dr = 4'b0000;
        dc = 4'b0000;
        unique case (dir)
            3'd0: begin dr = 4'b1111; dc = 4'b0000; end
            3'd1: begin dr = 4'b1111; dc = 4'b0001; end
            3'd2: begin dr = 4'b0000; dc = 4'b0001; end
            3'd3: begin dr = 4'b0001; dc = 4'b0001; end
            3'd4: begin dr = 4'b0001; dc = 4'b0000; end
            3'd5: begin dr = 4'b0001; dc = 4'b1111; end
            3'd6: begin dr = 4'b0000; dc = 4'b1111; end
            3'd7: begin dr = 4'b1111; dc = 4'b1111; end
            default: begin dr = 4'b0000; dc = 4'b0000; end
        endcase
    end

    assign org_nr  = {1'b0, org_r} + dr;
    assign org_nc  = {1'b0, org_c} + dc;
    assign cur_nr  = {1'b0, cur_r} + dr;
    assign cur_nc  = {1'b0, cur_c} + dc;
    assign org_out = org_nr[3] | org_nc[3];
    assign cur_out = cur_nr[3] | cur_nc[3];
    assign is_opp  = (rd_data == opp);
    assign is_own  = (rd_data == own);

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (start) state_next = RD_ORG;
            RD_ORG:    state_next = CHK_ORG;
            CHK_ORG:   state_next = (rd_data != 2'b00) ? DONE : DIR_INIT;
            DIR_INIT:  state_next = org_out ? NEXT_DIR : SCAN_RD;
            SCAN_RD:   state_next = SCAN_EVAL;
            SCAN_EVAL: begin
                if (is_opp)                   state_next = cur_out ? NEXT_DIR : SCAN_RD;
                else if (is_own && cnt != '0) state_next = FLIP;
                else                          state_next = NEXT_DIR;
            end
            FLIP:      state_next = (cnt == 3'd1) ? NEXT_DIR : FLIP;
            NEXT_DIR: begin
                if (dir == 3'd7) state_next = (total != '0) ? PLACE : DONE;
                else             state_next = DIR_INIT;
            end
            PLACE:     state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            org_r   <= '0;
            org_c   <= '0;
            cur_r   <= '0;
            cur_c   <= '0;
            dir     <= '0;
            cnt     <= '0;
            ply     <= 1'b0;
            total   <= '0;
            valid_r <= 1'b0;
            flips_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        org_r <= row;
                        org_c <= col;
                        ply   <= player;
                        total <= '0;
                        dir   <= '0;
                    end
                end
                DIR_INIT: begin
                    cnt   <= '0;
                    cur_r <= org_nr[2:0];
                    cur_c <= org_nc[2:0];
                end
                SCAN_EVAL: begin
                    if (is_opp) begin
                        cnt   <= cnt + 3'd1;
                        cur_r <= cur_nr[2:0];
                        cur_c <= cur_nc[2:0];
                    end else if (is_own && cnt != '0) begin
                        // Rewind to the nearest cell so flips go outward from the origin.
                        cur_r <= org_nr[2:0];
                        cur_c <= org_nc[2:0];
                    end
                end
                FLIP: begin
                    cur_r <= cur_nr[2:0];
                    cur_c <= cur_nc[2:0];
                    cnt   <= cnt - 3'd1;
                    total <= total + 5'd1;
                end
                NEXT_DIR: begin
                    if (dir != 3'd7) dir <= dir + 3'd1;
                end
                default: ;
            endcase
            if (state != DONE && state_next == DONE) begin
                valid_r <= (state == PLACE);
                flips_r <= total;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign valid   = valid_r;
    assign flips   = flips_r;
    assign rd_addr = (state == SCAN_RD) ? {cur_r, cur_c} : {org_r, org_c};
    assign wr_en   = reset && (state == FLIP || state == PLACE);
    assign wr_addr = (state == FLIP)  ? {cur_r, cur_c} :
                     (state == PLACE) ? {org_r, org_c} : '0;
    assign wr_data = (state == FLIP || state == PLACE) ? own : '0;

endmodule
